// File: rtl/cgb_pixel_mixer.sv
// cgb_pixel_mixer: resolves CGB BG/sprite priority per pixel, expands RGB555 to RGB888 and
// queues {address, color} for the framebuffer behind a first-word fall-through FIFO.
module cgb_pixel_mixer #(
   parameter int FIFO_DEPTH = 8,
   parameter int SCREEN_W   = 160,
   parameter int SCREEN_H   = 144
) (
   input  logic        I_CLK,
   input  logic        I_RESET,
   input  logic        I_FRAME_START,
   input  logic        I_PIX_VALID,
   input  logic [2:0]  I_BG_PAL,
   input  logic [1:0]  I_BG_IDX,
   input  logic        I_BG_PRIO,
   input  logic        I_SPR_VALID,
   input  logic [2:0]  I_SPR_PAL,
   input  logic [1:0]  I_SPR_IDX,
   input  logic        I_SPR_BEHIND,
   input  logic        I_MASTER_PRIO,
   output logic        O_STALL,
   output logic [2:0]  O_BGPAL_SEL,
   output logic [1:0]  O_BGPAL_INDEX,
   output logic [2:0]  O_SPRPAL_SEL,
   output logic [1:0]  O_SPRPAL_INDEX,
   input  logic [15:0] I_BGPAL_COLOR,
   input  logic [15:0] I_SPRPAL_COLOR,
   output logic        O_FB_VALID,
   input  logic        I_FB_READY,
   output logic [14:0] O_FB_ADDR,
   output logic [23:0] O_FB_DATA,
   output logic        O_OVERFLOW
);
   localparam int XW = $clog2(SCREEN_W);
   localparam int YW = $clog2(SCREEN_H);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int OW = CW + 1;

   typedef struct packed {
      logic [14:0] addr;
      logic [23:0] rgb;
   } fb_entry_t;

   logic [XW-1:0] x_q, cur_x, s1_x;
   logic [YW-1:0] y_q, cur_y, s1_y;

   logic          s1_valid;
   logic [2:0]    s1_bg_pal, s1_spr_pal;
   logic [1:0]    s1_bg_idx, s1_spr_idx;
   logic          s1_bg_prio, s1_spr_valid, s1_spr_behind, s1_master_prio;

   fb_entry_t     fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic          overflow_q;

   logic          stall, capture, push, pop, use_spr, spr_opaque;
   logic [OW-1:0] occupancy;
   fb_entry_t     mix_entry;

   // The color file returns the low palette byte in [15:8]; swap before splitting channels.
   function automatic logic [23:0] rgb555_to_888(input logic [15:0] color);
      logic [14:0] c;
      c = {color[6:0], color[15:8]};
      return {c[4:0], c[4:2], c[9:5], c[9:7], c[14:10], c[14:12]};
   endfunction

   // NOTE: every signal gets a value at the top of always_comb so no path can infer a latch.
   always_comb begin
      occupancy  = {1'b0, count} + OW'(s1_valid);
      stall      = occupancy >= OW'(FIFO_DEPTH - 1);
      capture    = I_PIX_VALID && !stall;
      cur_x      = I_FRAME_START ? '0 : x_q;
      cur_y      = I_FRAME_START ? '0 : y_q;

      spr_opaque = s1_spr_valid && (s1_spr_idx != 2'd0);
      use_spr    = spr_opaque &&
                   (!s1_master_prio || (s1_bg_idx == 2'd0) || !(s1_bg_prio || s1_spr_behind));

      mix_entry.addr = 15'(int'(s1_y) * SCREEN_W + int'(s1_x));
      mix_entry.rgb  = use_spr ? rgb555_to_888(I_SPRPAL_COLOR) : rgb555_to_888(I_BGPAL_COLOR);

      pop        = (count != '0) && I_FB_READY;
      push       = s1_valid && ((count != CW'(FIFO_DEPTH)) || pop);
   end

   assign O_STALL        = stall;
   assign O_BGPAL_SEL    = s1_bg_pal;
   assign O_BGPAL_INDEX  = s1_bg_idx;
   assign O_SPRPAL_SEL   = s1_spr_pal;
   assign O_SPRPAL_INDEX = s1_spr_idx;
   assign O_FB_VALID     = (count != '0);
   assign O_FB_ADDR      = O_FB_VALID ? fifo_mem[rd_ptr].addr : '0;
   assign O_FB_DATA      = O_FB_VALID ? fifo_mem[rd_ptr].rgb  : '0;
   assign O_OVERFLOW     = overflow_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         x_q            <= '0;
         y_q            <= '0;
         s1_valid       <= 1'b0;
         s1_bg_pal      <= '0;
         s1_bg_idx      <= '0;
         s1_bg_prio     <= 1'b0;
         s1_spr_valid   <= 1'b0;
         s1_spr_pal     <= '0;
         s1_spr_idx     <= '0;
         s1_spr_behind  <= 1'b0;
         s1_master_prio <= 1'b0;
         s1_x           <= '0;
         s1_y           <= '0;
         rd_ptr         <= '0;
         wr_ptr         <= '0;
         count          <= '0;
         overflow_q     <= 1'b0;
      end else begin
         s1_valid <= capture;
         if (capture) begin
            s1_bg_pal      <= I_BG_PAL;
            s1_bg_idx      <= I_BG_IDX;
            s1_bg_prio     <= I_BG_PRIO;
            s1_spr_valid   <= I_SPR_VALID;
            s1_spr_pal     <= I_SPR_PAL;
            s1_spr_idx     <= I_SPR_IDX;
            s1_spr_behind  <= I_SPR_BEHIND;
            s1_master_prio <= I_MASTER_PRIO;
            s1_x           <= cur_x;
            s1_y           <= cur_y;
         end

         // Position advances for every offered pixel, dropped ones included.
         if (I_PIX_VALID) begin
            if (cur_x == XW'(SCREEN_W - 1)) begin
               x_q <= '0;
               y_q <= (cur_y == YW'(SCREEN_H - 1)) ? '0 : cur_y + 1'b1;
            end else begin
               x_q <= cur_x + 1'b1;
               y_q <= cur_y;
            end
         end else begin
            x_q <= cur_x;
            y_q <= cur_y;
         end

         if (I_FRAME_START)
            overflow_q <= 1'b0;
         if (I_PIX_VALID && stall)
            overflow_q <= 1'b1;

         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // NOTE: the storage array is not reset; only pointers and count are, and the head is masked while empty.
   always_ff @(posedge I_CLK) begin
      if (push)
         fifo_mem[wr_ptr] <= mix_entry;
   end
endmodule

// File: tb/tb_cgb_pixel_mixer.sv
// tb_cgb_pixel_mixer: random and directed pixel stimulus against a behavioural mixer model;
// a separate monitor pops expected framebuffer writes from a scoreboard queue.
module tb_cgb_pixel_mixer;
   localparam int FIFO_DEPTH = 8;
   localparam int SCREEN_W   = 160;
   localparam int SCREEN_H   = 144;

   typedef struct packed {
      logic [2:0] bg_pal;
      logic [1:0] bg_idx;
      logic       bg_prio;
      logic       spr_valid;
      logic [2:0] spr_pal;
      logic [1:0] spr_idx;
      logic       spr_behind;
      logic       master;
   } pix_t;

   logic        I_CLK, I_RESET, I_FRAME_START, I_PIX_VALID;
   logic [2:0]  I_BG_PAL, I_SPR_PAL;
   logic [1:0]  I_BG_IDX, I_SPR_IDX;
   logic        I_BG_PRIO, I_SPR_VALID, I_SPR_BEHIND, I_MASTER_PRIO;
   logic        O_STALL, O_FB_VALID, I_FB_READY, O_OVERFLOW;
   logic [2:0]  O_BGPAL_SEL, O_SPRPAL_SEL;
   logic [1:0]  O_BGPAL_INDEX, O_SPRPAL_INDEX;
   logic [15:0] I_BGPAL_COLOR, I_SPRPAL_COLOR;
   logic [14:0] O_FB_ADDR;
   logic [23:0] O_FB_DATA;

   // Color file model: combinational lookup from the DUT's select/index outputs.
   logic [15:0] bg_cf  [32];
   logic [15:0] spr_cf [32];
   assign I_BGPAL_COLOR  = bg_cf[{O_BGPAL_SEL, O_BGPAL_INDEX}];
   assign I_SPRPAL_COLOR = spr_cf[{O_SPRPAL_SEL, O_SPRPAL_INDEX}];

   cgb_pixel_mixer #(.FIFO_DEPTH(FIFO_DEPTH), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) dut (
      .I_CLK(I_CLK), .I_RESET(I_RESET), .I_FRAME_START(I_FRAME_START), .I_PIX_VALID(I_PIX_VALID),
      .I_BG_PAL(I_BG_PAL), .I_BG_IDX(I_BG_IDX), .I_BG_PRIO(I_BG_PRIO),
      .I_SPR_VALID(I_SPR_VALID), .I_SPR_PAL(I_SPR_PAL), .I_SPR_IDX(I_SPR_IDX),
      .I_SPR_BEHIND(I_SPR_BEHIND), .I_MASTER_PRIO(I_MASTER_PRIO), .O_STALL(O_STALL),
      .O_BGPAL_SEL(O_BGPAL_SEL), .O_BGPAL_INDEX(O_BGPAL_INDEX),
      .O_SPRPAL_SEL(O_SPRPAL_SEL), .O_SPRPAL_INDEX(O_SPRPAL_INDEX),
      .I_BGPAL_COLOR(I_BGPAL_COLOR), .I_SPRPAL_COLOR(I_SPRPAL_COLOR),
      .O_FB_VALID(O_FB_VALID), .I_FB_READY(I_FB_READY), .O_FB_ADDR(O_FB_ADDR),
      .O_FB_DATA(O_FB_DATA), .O_OVERFLOW(O_OVERFLOW)
   );

   int          n_checks, n_errs, n_accepted, n_popped;
   int          px, py;
   bit          ovf_m;
   logic [38:0] exp_q [$];

   initial begin
      I_CLK = 1'b0;
      forever #5 I_CLK = ~I_CLK;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] rgb888(input logic [15:0] c);
      int v, r, g, b;
      v = int'(c[7:0]) * 256 + int'(c[15:8]);
      r = v % 32;
      g = (v / 32) % 32;
      b = (v / 1024) % 32;
      return 24'((r * 8 + r / 4) * 65536 + (g * 8 + g / 4) * 256 + (b * 8 + b / 4));
   endfunction

   function automatic bit sprite_wins(input pix_t p);
      if (!(p.spr_valid && p.spr_idx != 2'd0)) return 1'b0;
      if (!p.master) return 1'b1;
      if (p.bg_idx == 2'd0) return 1'b1;
      if (p.bg_prio || p.spr_behind) return 1'b0;
      return 1'b1;
   endfunction

   function automatic pix_t mk(input logic [2:0] bp, input logic [1:0] bi, input logic bpr,
                               input logic sv, input logic [2:0] sp, input logic [1:0] si,
                               input logic sb, input logic m);
      pix_t p;
      p.bg_pal = bp; p.bg_idx = bi; p.bg_prio = bpr; p.spr_valid = sv;
      p.spr_pal = sp; p.spr_idx = si; p.spr_behind = sb; p.master = m;
      return p;
   endfunction

   function automatic pix_t rand_pix();
      return pix_t'($urandom_range(0, 32767));
   endfunction

   task automatic randomize_color_file();
      for (int i = 0; i < 32; i++) begin
         bg_cf[i]  = 16'($urandom);
         spr_cf[i] = 16'($urandom);
      end
   endtask

   // One clock slot: check stall/overflow against the model, drive inputs, update the model.
   task automatic step(input bit pv, input bit fs, input bit rdy, input pix_t p);
      int          outstanding;
      logic [23:0] rgb;
      @(negedge I_CLK);
      #1;
      outstanding = n_accepted - n_popped;
      check("stall", O_STALL, 64'(outstanding >= FIFO_DEPTH - 1));
      check("overflow", O_OVERFLOW, 64'(ovf_m));
      I_PIX_VALID   = pv;
      I_FRAME_START = fs;
      I_FB_READY    = rdy;
      I_BG_PAL      = p.bg_pal;
      I_BG_IDX      = p.bg_idx;
      I_BG_PRIO     = p.bg_prio;
      I_SPR_VALID   = p.spr_valid;
      I_SPR_PAL     = p.spr_pal;
      I_SPR_IDX     = p.spr_idx;
      I_SPR_BEHIND  = p.spr_behind;
      I_MASTER_PRIO = p.master;
      if (fs) begin
         px = 0; py = 0; ovf_m = 1'b0;
      end
      if (pv) begin
         if (outstanding >= FIFO_DEPTH - 1) begin
            ovf_m = 1'b1;
         end else begin
            rgb = sprite_wins(p) ? rgb888(spr_cf[{p.spr_pal, p.spr_idx}])
                                 : rgb888(bg_cf[{p.bg_pal, p.bg_idx}]);
            exp_q.push_back({15'(py * SCREEN_W + px), rgb});
            n_accepted++;
         end
         px++;
         if (px == SCREEN_W) begin
            px = 0;
            py = (py == SCREEN_H - 1) ? 0 : py + 1;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge I_CLK);
      #1;
      I_RESET = 1'b1; I_PIX_VALID = 1'b0; I_FRAME_START = 1'b0;
      exp_q.delete();
      n_accepted = 0; n_popped = 0; px = 0; py = 0; ovf_m = 1'b0;
      @(negedge I_CLK);
      #1;
      I_RESET = 1'b0;
      check("rst_fb_valid", O_FB_VALID, 0);
      check("rst_stall", O_STALL, 0);
      check("rst_overflow", O_OVERFLOW, 0);
      check("rst_lookup", {O_BGPAL_SEL, O_BGPAL_INDEX, O_SPRPAL_SEL, O_SPRPAL_INDEX}, 0);
      check("rst_fb_addr", O_FB_ADDR, 0);
      check("rst_fb_data", O_FB_DATA, 0);
   endtask

   // Monitor: just before each rising edge, a handshake pops one expected entry.
   always begin
      @(negedge I_CLK);
      #3;
      if (!I_RESET && O_FB_VALID && I_FB_READY) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errs++;
            $display("FAIL fb_unexpected: got addr %0d data %06h, expected no entry", O_FB_ADDR, O_FB_DATA);
         end else begin
            check("fb_entry", {O_FB_ADDR, O_FB_DATA}, exp_q.pop_front());
         end
         n_popped++;
      end
   end

   pix_t        sweep_pix [5];
   logic [23:0] sweep_rgb [5];

   initial begin
      n_checks = 0; n_errs = 0; n_accepted = 0; n_popped = 0;
      px = 0; py = 0; ovf_m = 1'b0;
      I_RESET = 1'b1; I_FRAME_START = 1'b0; I_PIX_VALID = 1'b0; I_FB_READY = 1'b0;
      {I_BG_PAL, I_BG_IDX, I_BG_PRIO, I_SPR_VALID, I_SPR_PAL, I_SPR_IDX, I_SPR_BEHIND, I_MASTER_PRIO} = '0;
      randomize_color_file();
      do_reset();

      // First pixel: lookup ports follow stage 1, head appears one cycle later.
      bg_cf[{3'd3, 2'd1}] = 16'h1F00;
      step(1, 0, 1, mk(3'd3, 2'd1, 0, 0, 3'd0, 2'd0, 0, 1));
      step(0, 0, 1, '0);
      check("bgpal_sel", O_BGPAL_SEL, 3);
      check("bgpal_index", O_BGPAL_INDEX, 1);
      step(0, 0, 1, '0);
      check("first_valid", O_FB_VALID, 1);
      check("first_addr", O_FB_ADDR, 0);
      check("first_data", O_FB_DATA, 24'hFF0000);

      // Priority sweep: BG is red, sprite is green.
      for (int i = 0; i < 32; i++) begin
         bg_cf[i] = 16'h1F00;
         spr_cf[i] = 16'hE003;
      end
      sweep_pix[0] = mk(3'd1, 2'd1, 0, 1, 3'd2, 2'd0, 0, 1); sweep_rgb[0] = 24'hFF0000;
      sweep_pix[1] = mk(3'd1, 2'd1, 1, 1, 3'd2, 2'd1, 0, 0); sweep_rgb[1] = 24'h00FF00;
      sweep_pix[2] = mk(3'd1, 2'd0, 1, 1, 3'd2, 2'd2, 0, 1); sweep_rgb[2] = 24'h00FF00;
      sweep_pix[3] = mk(3'd1, 2'd2, 0, 1, 3'd2, 2'd3, 1, 1); sweep_rgb[3] = 24'hFF0000;
      sweep_pix[4] = mk(3'd1, 2'd2, 0, 1, 3'd2, 2'd1, 0, 1); sweep_rgb[4] = 24'h00FF00;
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 1, sweep_pix[i]);
         step(0, 0, 1, '0);
         step(0, 0, 1, '0);
         check("prio_valid", O_FB_VALID, 1);
         check("prio_data", O_FB_DATA, sweep_rgb[i]);
      end

      // Full frame back-to-back with the framebuffer always ready.
      randomize_color_file();
      step(1, 1, 1, rand_pix());
      for (int i = 1; i < SCREEN_W * SCREEN_H; i++)
         step(1, 0, 1, rand_pix());
      for (int i = 0; i < 4; i++)
         step(0, 0, 1, '0);

      // Backpressure: fill to the stall level, drop one, then restart the frame mid-line.
      do_reset();
      for (int i = 0; i < 12 && (n_accepted - n_popped) < FIFO_DEPTH - 1; i++)
         step(1, 0, 0, rand_pix());
      step(1, 0, 0, rand_pix());
      step(0, 0, 0, '0);
      for (int i = 0; i < 12; i++)
         step(0, 0, 1, '0);
      for (int i = 0; i < SCREEN_W && px != 57; i++)
         step(1, 0, 1, rand_pix());
      step(1, 1, 1, rand_pix());
      step(1, 0, 1, rand_pix());
      for (int i = 0; i < 4; i++)
         step(0, 0, 1, '0);

      // Reset with five FIFO entries and stage 1 occupied.
      for (int i = 0; i < 6; i++)
         step(1, 0, 0, rand_pix());
      do_reset();
      step(1, 0, 1, rand_pix());
      for (int i = 0; i < 4; i++)
         step(0, 0, 1, '0);

      // Random traffic with backpressure, occasional violations and frame restarts.
      randomize_color_file();
      for (int i = 0; i < 1500; i++) begin
         bit stalled, pv, fs;
         stalled = (n_accepted - n_popped) >= FIFO_DEPTH - 1;
         pv = stalled ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 7);
         fs = !stalled && ($urandom_range(0, 99) == 0);
         step(pv, fs, $urandom_range(0, 9) < 6, rand_pix());
      end

      for (int i = 0; i < 50 && exp_q.size() != 0; i++)
         step(0, 0, 1, '0);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errs++;
         $display("FAIL drain: %0d entries still pending, expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
      $finish;
   end
endmodule
